// File: rtl/aq_djpeg_bitbuf_if.sv
`default_nettype none
// ============================================================================
//  Module      : aq_djpeg_bitbuf_if
//  Description : Stream-in / peek-out bundle for the djpeg bit buffer.
//                "slave" is the buffer side, "master" the feeding/consuming
//                side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface aq_djpeg_bitbuf_if #(
    parameter int IN_BYTES   = 4,
    parameter int PEEK_WIDTH = 32,
    parameter int BUF_BITS   = 128
);
    localparam int c_FILL_W = $clog2(BUF_BITS + 1);
    localparam int c_USE_W  = $clog2(PEEK_WIDTH + 1);

    logic [8*IN_BYTES-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  image_en;
    logic [PEEK_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic [c_FILL_W-1:0]   out_fill;
    logic                  use_en;
    logic [c_USE_W-1:0]    use_width;
    logic                  align_en;
    logic                  flush;
    logic                  marker_hit;
    logic [7:0]            marker_code;
    logic                  marker_ack;
    logic                  err;

    modport slave (
        input  in_data, in_valid, image_en, use_en, use_width, align_en,
               flush, marker_ack,
        output in_ready, out_data, out_valid, out_fill, marker_hit,
               marker_code, err
    );

    modport master (
        output in_data, in_valid, image_en, use_en, use_width, align_en,
               flush, marker_ack,
        input  in_ready, out_data, out_valid, out_fill, marker_hit,
               marker_code, err
    );
endinterface
`default_nettype wire

// File: rtl/aq_djpeg_bitbuf.sv
`default_nettype none
// ============================================================================
//  Module      : aq_djpeg_bitbuf
//  Description : JPEG front-end bit buffer. Takes little-endian multi-byte
//                words, optionally removes 0xFF00 stuffing and stops on
//                markers, and presents an MSB-aligned peek window that the
//                Huffman/header parsers consume bit-wise.
//  Revision    : 1.0 - initial release
// ============================================================================
module aq_djpeg_bitbuf #(
    parameter int IN_BYTES   = 4,
    parameter int PEEK_WIDTH = 32,
    parameter int BUF_BITS   = 128
) (
    input  wire logic          clk,
    input  wire logic          rst,
    aq_djpeg_bitbuf_if.slave   bus
);
    localparam int c_IN_BITS = 8 * IN_BYTES;
    localparam int c_FILL_W  = $clog2(BUF_BITS + 1);

    // Buffer holds valid bits left-aligned; every bit below the fill level
    // is kept at zero so the peek window needs no masking.
    logic [BUF_BITS-1:0]  r_buf;
    logic [c_FILL_W-1:0]  r_fill;
    logic                 r_pendFf;
    logic                 r_markerHit;
    logic [7:0]           r_markerCode;
    logic                 r_err;
    logic                 r_live;

    logic                 w_inReady;
    logic                 w_accept;
    logic [c_IN_BITS-1:0] w_appBits;
    logic [c_FILL_W-1:0]  w_appN;
    logic                 w_scanPend;
    logic                 w_scanMarker;
    logic [7:0]           w_scanCode;
    logic [c_FILL_W-1:0]  w_useReq;
    logic [c_FILL_W-1:0]  w_useAmt;
    logic                 w_overUse;
    logic [c_FILL_W-1:0]  w_fillAfter;
    logic [BUF_BITS-1:0]  w_shifted;
    logic [BUF_BITS-1:0]  w_appWide;
    logic [BUF_BITS-1:0]  w_bufNext;
    logic [c_FILL_W-1:0]  w_fillNext;

    // Ready depends only on registered state; r_live holds it low for the
    // cycle right after reset.
    assign w_inReady = r_live & ~r_markerHit
                     & (r_fill <= c_FILL_W'(BUF_BITS - c_IN_BITS));
    assign w_accept  = bus.in_valid & w_inReady;

    // Byte scan, lane 0 first: packs surviving bytes left-aligned into
    // w_appBits and tracks stuffing/marker state seeded by r_pendFf.
    always_comb begin
        logic [7:0] v_byte;
        int         v_pos;
        w_appBits    = '0;
        w_scanPend   = r_pendFf & bus.image_en;
        w_scanMarker = 1'b0;
        w_scanCode   = 8'h00;
        v_byte       = 8'h00;
        v_pos        = c_IN_BITS;
        for (int i = 0; i < IN_BYTES; i++) begin
            v_byte = bus.in_data[8*i +: 8];
            if (!w_scanMarker) begin
                if (!bus.image_en || (!w_scanPend && v_byte != 8'hFF)) begin
                    v_pos = v_pos - 8;
                    w_appBits[v_pos +: 8] = v_byte;
                end else if (!w_scanPend) begin
                    w_scanPend = 1'b1;
                end else if (v_byte == 8'h00) begin
                    v_pos = v_pos - 8;
                    w_appBits[v_pos +: 8] = 8'hFF;
                    w_scanPend = 1'b0;
                end else if (v_byte != 8'hFF) begin
                    // Marker: remaining lanes of this word are dropped.
                    w_scanMarker = 1'b1;
                    w_scanCode   = v_byte;
                    w_scanPend   = 1'b0;
                end
                // pend with 0xFF is a fill byte: stay pending, append nothing.
            end
        end
        w_appN = c_FILL_W'(c_IN_BITS - v_pos);
    end

    // Consume/align amount: consume wins over align; consume is clamped to
    // the bits actually held.
    always_comb begin
        w_useReq  = c_FILL_W'(bus.use_width);
        w_overUse = 1'b0;
        w_useAmt  = '0;
        if (bus.use_en) begin
            if (w_useReq > r_fill) begin
                w_overUse = 1'b1;
                w_useAmt  = r_fill;
            end else begin
                w_useAmt  = w_useReq;
            end
        end else if (bus.align_en) begin
            w_useAmt = {{(c_FILL_W-3){1'b0}}, r_fill[2:0]};
        end
    end

    // Next buffer image: shift out consumed bits, then splice the appended
    // bytes directly below the remaining ones.
    always_comb begin
        w_fillAfter = r_fill - w_useAmt;
        w_shifted   = r_buf << w_useAmt;
        w_appWide   = {w_appBits, {(BUF_BITS-c_IN_BITS){1'b0}}} >> w_fillAfter;
        w_bufNext   = w_shifted;
        w_fillNext  = w_fillAfter;
        if (w_accept) begin
            w_bufNext  = w_shifted | w_appWide;
            w_fillNext = w_fillAfter + w_appN;
        end
    end

    // State update: reset, then flush, then consume/append and marker logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf        <= '0;
            r_fill       <= '0;
            r_pendFf     <= 1'b0;
            r_markerHit  <= 1'b0;
            r_markerCode <= 8'h00;
            r_err        <= 1'b0;
            r_live       <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (bus.flush) begin
                r_buf        <= '0;
                r_fill       <= '0;
                r_pendFf     <= 1'b0;
                r_markerHit  <= 1'b0;
                r_markerCode <= 8'h00;
            end else begin
                r_buf  <= w_bufNext;
                r_fill <= w_fillNext;
                if (w_overUse || (bus.use_en && bus.align_en)) begin
                    r_err <= 1'b1;
                end
                if (w_accept) begin
                    r_pendFf <= w_scanPend;
                    if (w_scanMarker) begin
                        r_markerHit  <= 1'b1;
                        r_markerCode <= w_scanCode;
                    end
                end else if (r_markerHit && bus.marker_ack) begin
                    r_markerHit <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready    = w_inReady;
    assign bus.out_data    = r_buf[BUF_BITS-1 -: PEEK_WIDTH];
    assign bus.out_fill    = r_fill;
    assign bus.out_valid   = (r_fill >= c_FILL_W'(PEEK_WIDTH))
                           | (r_markerHit & (r_fill != '0));
    assign bus.marker_hit  = r_markerHit;
    assign bus.marker_code = r_markerCode;
    assign bus.err         = r_err;
endmodule
`default_nettype wire

// File: doc/aq_djpeg_bitbuf.md
Name: aq_djpeg_bitbuf

Overview:
- Parametrised successor to the JPEG register-data front end.
- Accepts a little-endian multi-byte word stream and, in image mode, removes 0xFF00 stuffing and stops cleanly on any marker, including when the 0xFF and its code byte arrive in different words.
- Presents an MSB-aligned peek window to the Huffman/header parsers, which consume 0..PEEK_WIDTH bits per cycle.
- Sits between the AXI-stream input adapter and the djpeg header/Huffman decoders.

Parameters:
- IN_BYTES, 4: bytes per input word; lane 0 = DataIn[7:0] is the first byte in stream order.
- PEEK_WIDTH, 32: width of the output peek window in bits, a multiple of 8.
- BUF_BITS, 128: bit-buffer capacity; must be ≥ PEEK_WIDTH + 8*IN_BYTES + 8.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  8*IN_BYTES  input word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  word accepted when in_valid & in_ready.
- image_en  in  1  1 = entropy-coded mode (unstuff, marker stop); 0 = raw header mode.
- out_data  out  PEEK_WIDTH  next unconsumed bits, MSB first, left-aligned, zero-padded below the fill level.
- out_valid  out  1  out_fill ≥ PEEK_WIDTH, or marker_hit & out_fill > 0.
- out_fill  out  $clog2(BUF_BITS+1)  valid bits held.
- use_en  in  1  consume use_width bits this cycle.
- use_width  in  $clog2(PEEK_WIDTH+1)  bits to consume, 0..PEEK_WIDTH.
- align_en  in  1  discard out_fill mod 8 bits (byte align).
- flush  in  1  discard all buffered state.
- marker_hit  out  1  marker found; input stalled.
- marker_code  out  8  byte following the 0xFF.
- marker_ack  in  1  release marker stall.
- err  out  1  sticky: over-consume, or use_en together with align_en.

Behaviour:
- Reset (rst=1 at clk edge): fill=0, pend_ff=0, marker_hit=0, marker_code=0, err=0. All outputs read 0 except in_ready, which rises the cycle after reset releases.
- Priority per cycle: rst > flush > (consume/align + append).
- flush clears the same state as reset except err.
- in_ready = ~marker_hit & (BUF_BITS − fill ≥ 8*IN_BYTES). Computed from registered state only; no combinational path from use_en.
- Raw mode (image_en=0): all IN_BYTES bytes are appended in lane order. No stuffing or marker checks. pend_ff is forced to 0.
- Image mode byte scan, lane 0 upward, with pend_ff seeding the state before lane 0:
  - byte≠FF and ~pend: append the byte.
  - byte=FF and ~pend: set pend, append nothing.
  - pend and byte=00: append 0xFF, clear pend.
  - pend and byte=FF: fill byte; keep pend, append nothing.
  - pend and other byte: marker. Set marker_hit, latch marker_code, clear pend, and drop the remaining lanes of the word.
- pend_ff carries across word boundaries.
- Append timing: appended bytes are visible in out_data and out_fill the cycle after acceptance (1-cycle latency).
- Bits appended per word: 0..8*IN_BYTES.
- Consume: with use_en, new fill = fill − use_width + appended.
  - Simultaneous consume and append is legal; consume applies to pre-append bits.
  - use_width > fill: clamp to fill and set err.
  - use_width=0 is a no-op.
- align_en: fill −= fill mod 8. Issuing it together with use_en sets err, and the consume takes effect.
- Marker stall: while marker_hit=1, no input is accepted, and remaining bits can still be peeked and consumed.
- marker_ack (only meaningful when marker_hit=1): clears marker_hit next cycle. marker_code holds until the next marker.
- Mode switch: image_en is sampled per accepted word. Changing it mid-word is not possible; buffered bits are unaffected.
- Full: in_ready=0 until enough space exists; no overflow possible.
- Empty: out_data=0, out_valid=0.

Test Plan:
- Raw mode: input 0x44332211 then 0x88776655 → after 2 accepts, out_data=0x11223344, out_fill=64. use_en, use_width=8 → out_data=0x22334455, out_fill=56.
- Image mode with word bytes AB FF 00 CD → appended bytes AB FF CD, out_fill=24; 4th byte after the next word gives out_data=0xABFFCD00 once fill ≥ 32.
- Split stuffing: word 1 ends in FF, word 2 starts with 00 → single 0xFF appended, pend_ff cleared. Word 1 ends in FF, word 2 = D9 xx xx xx → marker_hit=1, marker_code=0xD9, in_ready=0, lanes 1–3 dropped.
- Marker stall: keep in_valid=1 during marker_hit → no acceptance. Consume all bits → out_fill=0, out_valid=0. marker_ack → in_ready=1 next cycle.
- Fill sequence FF FF FF 00 → one 0xFF appended. Over-consume with use_width=32 at fill=12 → fill=0, err=1, and err stays set after flush.
- Assert rst mid-stream with fill=72 and pend_ff=1 → next cycle fill=0, marker_hit=0, err=0. Input 00 11 22 33 → bytes 00 appended, not treated as stuffing.
